// File: rtl/rename_pkg.sv
// Shared rename-stage types and sizes.
// Used by the physical register free list and the speculative RAT.
package rename_pkg;
  localparam int PHY_NUM  = 128;
  localparam int ARCH_NUM = 32;
  localparam int PREG_W   = 7;
  localparam int FL_DEPTH = PHY_NUM - ARCH_NUM;
  localparam int PTR_W    = 7;

  typedef logic [PREG_W-1:0] preg_t;
  typedef logic [4:0]        areg_t;
  typedef logic [PTR_W-1:0]  ptr_t;
  typedef logic [PTR_W-1:0]  cnt_t;

  // depth is not a power of two, so wrap explicitly
  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(FL_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
endpackage

// File: rtl/fl_ptr.sv
// Wrap-at-depth free list pointer with increment and restore load.
// Load wins over increment.
module fl_ptr
  import rename_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic load,
  input  ptr_t load_val,
  output ptr_t ptr
);

  always_ff @(posedge clk) begin
    if (rst)
      ptr <= '0;
    else if (load)
      ptr <= load_val;
    else if (inc)
      ptr <= ptr_inc(ptr);
  end

endmodule

// File: rtl/phy_freelist.sv
// Circular physical register free list with flush rollback.
// Define FREELIST_CHECK_EN to build the sticky protocol error checker.
module phy_freelist
  import rename_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  alloc_req,
  output logic  alloc_ok,
  output preg_t alloc_preg,
  input  logic  commit_en,
  input  logic  rel_en,
  input  preg_t rel_preg,
  input  logic  flush,
  output logic  empty,
  output cnt_t  free_cnt,
  output logic  err
);

  preg_t mem [FL_DEPTH];
  ptr_t  spec_head, commit_head, tail;
  ptr_t  commit_head_nxt;
  cnt_t  spec_cnt, commit_cnt;
  cnt_t  spec_cnt_nxt, commit_cnt_nxt;
  logic  rel_ok;

  // a release into a full list is dropped
  assign rel_ok = rel_en & (commit_cnt != cnt_t'(FL_DEPTH));

  assign alloc_ok   = alloc_req & (spec_cnt != '0) & ~flush;
  assign alloc_preg = mem[spec_head];
  assign empty      = (spec_cnt == '0);
  assign free_cnt   = spec_cnt;

  assign commit_head_nxt =
    commit_en ? ptr_inc(commit_head) : commit_head;

  assign commit_cnt_nxt =
    commit_cnt + cnt_t'(rel_ok) - cnt_t'(commit_en);

  assign spec_cnt_nxt = flush ? commit_cnt_nxt :
    spec_cnt + cnt_t'(rel_ok) - cnt_t'(alloc_ok);

  fl_ptr u_spec_head (
    .clk      (clk),
    .rst      (rst),
    .inc      (alloc_ok),
    .load     (flush),
    .load_val (commit_head_nxt),
    .ptr      (spec_head)
  );

  fl_ptr u_commit_head (
    .clk      (clk),
    .rst      (rst),
    .inc      (commit_en),
    .load     (1'b0),
    .load_val ('0),
    .ptr      (commit_head)
  );

  fl_ptr u_tail (
    .clk      (clk),
    .rst      (rst),
    .inc      (rel_ok),
    .load     (1'b0),
    .load_val ('0),
    .ptr      (tail)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FL_DEPTH; i++)
        mem[i] <= preg_t'(ARCH_NUM + i);
    end else if (rel_ok) begin
      mem[tail] <= rel_preg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      spec_cnt   <= cnt_t'(FL_DEPTH);
      commit_cnt <= cnt_t'(FL_DEPTH);
    end else begin
      spec_cnt   <= spec_cnt_nxt;
      commit_cnt <= commit_cnt_nxt;
    end
  end

`ifdef FREELIST_CHECK_EN
  logic err_q, committed;
  logic bad_rel, bad_commit, bad_preg;

  assign bad_rel    = rel_en & (commit_cnt == cnt_t'(FL_DEPTH));
  assign bad_commit = commit_en & (commit_cnt == spec_cnt);
  assign bad_preg   = rel_en & committed
                    & (rel_preg < preg_t'(ARCH_NUM));

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q     <= 1'b0;
      committed <= 1'b0;
    end else begin
      if (commit_en)
        committed <= 1'b1;
      if (bad_rel | bad_commit | bad_preg)
        err_q <= 1'b1;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!bad_rel)
        else $error("release into full free list");
      assert (!bad_commit)
        else $error("commit without outstanding alloc");
      assert (!bad_preg)
        else $error("initial mapping tag released");
    end
  end
`endif

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_phy_freelist.sv
// Scoreboard bench for phy_freelist: directed cycles push expectations,
// a negedge monitor pops and compares the combinational outputs.
module tb_phy_freelist;
  import rename_pkg::*;

`ifdef FREELIST_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  typedef struct {
    string tag;
    logic  ok;
    preg_t preg;
    cnt_t  cnt;
    logic  emp;
    logic  err;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  logic  alloc_req = 1'b0;
  logic  alloc_ok;
  preg_t alloc_preg;
  logic  commit_en = 1'b0;
  logic  rel_en = 1'b0;
  preg_t rel_preg = '0;
  logic  flush = 1'b0;
  logic  empty;
  cnt_t  free_cnt;
  logic  err;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  phy_freelist dut (
    .clk        (clk),
    .rst        (rst),
    .alloc_req  (alloc_req),
    .alloc_ok   (alloc_ok),
    .alloc_preg (alloc_preg),
    .commit_en  (commit_en),
    .rel_en     (rel_en),
    .rel_preg   (rel_preg),
    .flush      (flush),
    .empty      (empty),
    .free_cnt   (free_cnt),
    .err        (err)
  );

  function automatic exp_t mk(input string tag, input logic ok,
                              input int preg, input int cnt,
                              input logic emp, input logic e);
    exp_t x;
    x.tag  = tag;
    x.ok   = ok;
    x.preg = preg_t'(preg);
    x.cnt  = cnt_t'(cnt);
    x.emp  = emp;
    x.err  = e;
    return x;
  endfunction

  task automatic cmp(input string tag, input string fld,
                     input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s.%s got %0d want %0d", tag, fld, act, req);
    end
  endtask

  // monitor: one expectation per checked cycle, popped mid-cycle
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      cmp(e.tag, "alloc_ok", int'(alloc_ok), int'(e.ok));
      if (e.ok)
        cmp(e.tag, "alloc_preg", int'(alloc_preg), int'(e.preg));
      cmp(e.tag, "free_cnt", int'(free_cnt), int'(e.cnt));
      cmp(e.tag, "empty", int'(empty), int'(e.emp));
      cmp(e.tag, "err", int'(err), int'(e.err));
    end
  end

  task automatic cyc(input logic req, input logic cm,
                     input logic rl, input int rp, input logic fl,
                     input bit chk, input exp_t e);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    alloc_req = req;
    commit_en = cm;
    rel_en    = rl;
    rel_preg  = preg_t'(rp);
    flush     = fl;
    if (chk)
      sb.push_back(e);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst       = 1'b1;
    alloc_req = 1'b0;
    commit_en = 1'b0;
    rel_en    = 1'b0;
    flush     = 1'b0;
    @(posedge clk);
  endtask

  exp_t nx;

  initial begin
    nx = mk("none", 0, 0, 0, 0, 0);
    do_reset();

    // reset state, then three back-to-back allocations
    cyc(0, 0, 0, 0, 0, 1, mk("rst", 0, 0, 96, 0, 0));
    cyc(1, 0, 0, 0, 0, 1, mk("a3_0", 1, 32, 96, 0, 0));
    cyc(1, 0, 0, 0, 0, 1, mk("a3_1", 1, 33, 95, 0, 0));
    cyc(1, 0, 0, 0, 0, 1, mk("a3_2", 1, 34, 94, 0, 0));
    cyc(0, 0, 0, 0, 0, 1, mk("a3_end", 0, 0, 93, 0, 0));

    // drain the whole list, then one refused request
    do_reset();
    for (int i = 0; i < 96; i++)
      cyc(1, 0, 0, 0, 0, 1, mk("drain", 1, 32 + i, 96 - i, 0, 0));
    cyc(1, 0, 0, 0, 0, 1, mk("drain_empty", 0, 0, 0, 1, 0));

    // empty list: release with no bypass, tag usable next cycle
    cyc(0, 1, 0, 0, 0, 1, mk("emp_commit", 0, 0, 0, 1, 0));
    cyc(1, 0, 1, 5, 0, 1, mk("emp_rel", 0, 0, 0, 1, 0));
    cyc(1, 0, 0, 0, 0, 1, mk("emp_next", 1, 5, 1, 0, CHK));
    cyc(0, 0, 0, 0, 0, 1, mk("emp_after", 0, 0, 0, 1, CHK));

    // five allocs, two commits, flush rolls back to head 2
    do_reset();
    for (int i = 0; i < 5; i++)
      cyc(1, 0, 0, 0, 0, 1, mk("fl_alloc", 1, 32 + i, 96 - i, 0, 0));
    cyc(0, 1, 0, 0, 0, 1, mk("fl_cm0", 0, 0, 91, 0, 0));
    cyc(0, 1, 0, 0, 0, 1, mk("fl_cm1", 0, 0, 91, 0, 0));
    cyc(1, 0, 0, 0, 1, 1, mk("fl_flush", 0, 0, 91, 0, 0));
    cyc(1, 0, 0, 0, 0, 1, mk("fl_after", 1, 34, 94, 0, 0));
    cyc(0, 0, 0, 0, 0, 1, mk("fl_end", 0, 0, 93, 0, 0));

    // flush together with commit and release
    do_reset();
    for (int i = 0; i < 4; i++)
      cyc(1, 0, 0, 0, 0, 1, mk("fcr_alloc", 1, 32 + i, 96 - i, 0, 0));
    cyc(0, 1, 0, 0, 0, 1, mk("fcr_cm", 0, 0, 92, 0, 0));
    cyc(1, 1, 1, 40, 1, 1, mk("fcr_flush", 0, 0, 92, 0, 0));
    for (int i = 0; i < 94; i++)
      cyc(1, 0, 0, 0, 0, 1, mk("fcr_walk", 1, 34 + i, 95 - i, 0, 0));
    cyc(1, 0, 0, 0, 0, 1, mk("fcr_tail", 1, 40, 1, 0, 0));
    cyc(0, 0, 0, 0, 0, 1, mk("fcr_end", 0, 0, 0, 1, 0));

    // release into a full list is dropped and counters saturate
    do_reset();
    cyc(0, 0, 1, 50, 0, 1, mk("full_rel", 0, 0, 96, 0, 0));
    cyc(0, 0, 0, 0, 0, 1, mk("full_hold", 0, 0, 96, 0, CHK));
    cyc(1, 0, 0, 0, 0, 1, mk("full_alloc", 1, 32, 96, 0, CHK));
    cyc(0, 0, 0, 0, 0, 1, mk("full_end", 0, 0, 95, 0, CHK));

    cyc(0, 0, 0, 0, 0, 0, nx);
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got %0d want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
